// File: rtl/palette_arbiter_if.sv
// CPU-side request bus of the palette arbiter (PPUDATA accesses into the palette RAM).
interface palette_arbiter_if;
    logic       cpu_req;
    logic       cpu_wr;
    logic [4:0] cpu_addr;
    logic [7:0] cpu_wdata;
    logic       cpu_busy;
    logic       cpu_ack;
    logic [7:0] cpu_rdata;

    modport master (
        output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
        input  cpu_busy, cpu_ack, cpu_rdata
    );

    modport slave (
        input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
        output cpu_busy, cpu_ack, cpu_rdata
    );
endinterface

// File: rtl/palette_arbiter.sv
// Time-shares the single-port palette RAM between the renderer and one buffered CPU request.
// Optional greyscale masking of renderer colours is enabled by defining PAL_GREY_EN.
module palette_arbiter #(
    parameter int MAX_WAIT = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rend_en,
    input  logic [4:0]              rend_addr,
    output logic                    rend_valid,
    output logic [5:0]              rend_color,
    palette_arbiter_if.slave        cpu,
    input  logic                    grey,
    output logic [4:0]              pal_addr,
    output logic                    pal_wr,
    output logic [7:0]              pal_wdata,
    input  logic [7:0]              pal_rdata
);

    localparam int            WW       = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

    function automatic logic [WW-1:0] wait_inc(input logic [WW-1:0] w);
        return (w == WAIT_MAX) ? w : w + WW'(1);
    endfunction

    function automatic logic [4:0] backdrop_remap(input logic [4:0] a);
        return (a[1:0] == 2'b00) ? 5'h00 : a;
    endfunction

    logic          busy_q, pend_q;
    logic [WW-1:0] wait_q, wait_d;
    logic          buf_wr_q;
    logic [4:0]    buf_addr_q;
    logic [7:0]    buf_wdata_q;
    logic          grant_rend, grant_cpu, accept;

    logic          rend_vld_p1_q, steal_p1_q, cpu_p1_q, rd_p1_q;
    logic          rend_vld_p2_q, ack_p2_q;
    logic [5:0]    color_p2_q, color_d;
    logic [7:0]    rdata_p2_q;

`ifdef PAL_GREY_EN
    function automatic logic [5:0] grey_mask(input logic [5:0] c, input logic g);
        return g ? (c & 6'h30) : c;
    endfunction
    assign color_d = grey_mask(pal_rdata[5:0], grey);
`else
    logic unused_grey;
    assign unused_grey = grey;
    assign color_d     = pal_rdata[5:0];
`endif

    // Slot N: renderer owns the slot unless a pending CPU request has waited long enough.
    always_comb begin
        grant_rend = 1'b0;
        grant_cpu  = 1'b0;
        if (!rst) begin
            grant_cpu  = pend_q && (!rend_en || (wait_q == WAIT_MAX));
            grant_rend = rend_en && !grant_cpu;
        end
        pal_addr  = 5'h00;
        pal_wr    = 1'b0;
        pal_wdata = 8'h00;
        if (grant_cpu) begin
            pal_addr  = buf_addr_q;
            pal_wr    = buf_wr_q;
            pal_wdata = buf_wr_q ? buf_wdata_q : 8'h00;
        end else if (grant_rend) begin
            pal_addr = backdrop_remap(rend_addr);
        end
        accept = cpu.cpu_req && !busy_q;
        if (grant_cpu)
            wait_d = '0;
        else if (pend_q)
            wait_d = wait_inc(wait_q);
        else
            wait_d = wait_q;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            buf_wr_q    <= cpu.cpu_wr;
            buf_addr_q  <= cpu.cpu_addr;
            buf_wdata_q <= cpu.cpu_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q        <= 1'b0;
            pend_q        <= 1'b0;
            wait_q        <= '0;
            rend_vld_p1_q <= 1'b0;
            steal_p1_q    <= 1'b0;
            cpu_p1_q      <= 1'b0;
            rd_p1_q       <= 1'b0;
            rend_vld_p2_q <= 1'b0;
            ack_p2_q      <= 1'b0;
            color_p2_q    <= 6'h00;
            rdata_p2_q    <= 8'h00;
        end else begin
            wait_q <= wait_d;
            if (accept) begin
                busy_q <= 1'b1;
                pend_q <= 1'b1;
            end else begin
                if (grant_cpu) pend_q <= 1'b0;
                if (ack_p2_q)  busy_q <= 1'b0;
            end
            // Stage p1: RAM read in flight, remember who owns the slot
            rend_vld_p1_q <= grant_rend;
            steal_p1_q    <= grant_cpu && rend_en;
            cpu_p1_q      <= grant_cpu;
            rd_p1_q       <= grant_cpu && !buf_wr_q;
            // Stage p2: capture RAM data into the output registers
            rend_vld_p2_q <= rend_vld_p1_q || steal_p1_q;
            if (rend_vld_p1_q) color_p2_q <= color_d;
            ack_p2_q <= cpu_p1_q;
            if (cpu_p1_q && rd_p1_q) rdata_p2_q <= pal_rdata;
        end
    end

    assign rend_valid    = rend_vld_p2_q;
    assign rend_color    = color_p2_q;
    assign cpu.cpu_busy  = busy_q;
    assign cpu.cpu_ack   = ack_p2_q;
    assign cpu.cpu_rdata = rdata_p2_q;

endmodule

// File: tb/tb_palette_arbiter.sv
// Bench for palette_arbiter: directed literal scenarios, then randomized traffic against a slot-level model.
module tb_palette_arbiter;
    localparam int MAX_WAIT = 8;
    localparam int NCYC     = 8192;

    logic       clk = 1'b0;
    logic       rst, rend_en, grey;
    logic [4:0] rend_addr;
    logic       rend_valid;
    logic [5:0] rend_color;
    logic [4:0] pal_addr;
    logic       pal_wr;
    logic [7:0] pal_wdata;
    logic [7:0] pal_rdata;

    palette_arbiter_if cpu_bus();

    palette_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .rend_en(rend_en), .rend_addr(rend_addr),
        .rend_valid(rend_valid), .rend_color(rend_color),
        .cpu(cpu_bus), .grey(grey),
        .pal_addr(pal_addr), .pal_wr(pal_wr), .pal_wdata(pal_wdata),
        .pal_rdata(pal_rdata)
    );

    always #5 clk = ~clk;

    // Palette RAM: one-cycle registered read.
    logic [7:0] ram [32];
    always @(posedge clk) begin
        if (pal_wr) ram[pal_addr] <= pal_wdata;
        pal_rdata <= ram[pal_addr];
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] m_mem [32];
    logic       m_pend = 0, m_pw = 0, m_busy = 0, m_rst_prev = 1, m_grey_prev = 0;
    logic [4:0] m_pa = 0;
    logic [7:0] m_pd = 0;
    int         m_wait = 0;
    logic [5:0] m_color = 0;
    logic [7:0] m_rdata = 0;
    logic       s_rv [NCYC];
    logic       s_rend [NCYC];
    logic [5:0] s_color [NCYC];
    logic       s_ack [NCYC];
    logic       s_rd [NCYC];
    logic [7:0] s_rdata [NCYC];
    int         k = 0;
    logic       e_valid, e_ack, e_pwr, g_cpu, g_rend, acc;
    logic [4:0] e_paddr;

    function automatic logic [5:0] shade(input logic [5:0] c, input logic g);
`ifdef PAL_GREY_EN
        return g ? (c & 6'h30) : c;
`else
        return (g === 1'bx) ? c : c;
`endif
    endfunction

    always @(negedge clk) begin
        if (m_rst_prev) begin
            e_valid = 0; e_ack = 0; m_color = 0; m_rdata = 0;
        end else begin
            e_valid = s_rv[k];
            e_ack   = s_ack[k];
            if (s_rend[k]) m_color = shade(s_color[k], m_grey_prev);
            if (s_ack[k] && s_rd[k]) m_rdata = s_rdata[k];
        end
        check("rend_valid", 32'(rend_valid), 32'(e_valid));
        check("rend_color", 32'(rend_color), 32'(m_color));
        check("cpu_ack", 32'(cpu_bus.cpu_ack), 32'(e_ack));
        check("cpu_rdata", 32'(cpu_bus.cpu_rdata), 32'(m_rdata));
        check("cpu_busy", 32'(cpu_bus.cpu_busy), 32'(m_busy));

        g_cpu = 0; g_rend = 0;
        if (!rst) begin
            g_cpu  = m_pend && (!rend_en || m_wait == MAX_WAIT);
            g_rend = rend_en && !g_cpu;
        end
        e_paddr = 5'h00; e_pwr = 0;
        if (g_cpu) begin
            e_paddr = m_pa; e_pwr = m_pw;
        end else if (g_rend) begin
            e_paddr = (rend_addr[1:0] == 2'b00) ? 5'h00 : rend_addr;
        end
        check("pal_addr", 32'(pal_addr), 32'(e_paddr));
        check("pal_wr", 32'(pal_wr), 32'(e_pwr));
        if (g_cpu && m_pw) check("pal_wdata", 32'(pal_wdata), 32'(m_pd));

        if (k + 2 < NCYC) begin
            if (g_rend) begin
                s_rv[k+2] = 1; s_rend[k+2] = 1; s_color[k+2] = m_mem[e_paddr][5:0];
            end
            if (g_cpu) begin
                s_rv[k+2] = rend_en; s_ack[k+2] = 1; s_rd[k+2] = !m_pw;
                if (m_pw) m_mem[m_pa] = m_pd;
                else s_rdata[k+2] = m_mem[m_pa];
            end
        end
        if (g_cpu) begin
            m_pend = 0; m_wait = 0;
        end else if (m_pend && m_wait < MAX_WAIT) begin
            m_wait++;
        end
        acc = cpu_bus.cpu_req && !m_busy;
        if (e_ack) m_busy = 0;
        if (acc) begin
            m_busy = 1; m_pend = 1;
            m_pw = cpu_bus.cpu_wr; m_pa = cpu_bus.cpu_addr; m_pd = cpu_bus.cpu_wdata;
        end
        if (rst) begin
            m_pend = 0; m_wait = 0; m_busy = 0;
            for (int j = 1; j <= 2; j++) begin
                if (k + j < NCYC) begin
                    s_rv[k+j] = 0; s_rend[k+j] = 0; s_ack[k+j] = 0; s_rd[k+j] = 0;
                end
            end
        end
        m_rst_prev  = rst;
        m_grey_prev = grey;
        k++;
    end

    // ---------------- stimulus ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic cpu_pulse(input logic w, input logic [4:0] a, input logic [7:0] d);
        cpu_bus.cpu_req = 1; cpu_bus.cpu_wr = w; cpu_bus.cpu_addr = a; cpu_bus.cpu_wdata = d;
        next_cycle();
        cpu_bus.cpu_req = 0;
    endtask

    task automatic cpu_write_idle(input logic [4:0] a, input logic [7:0] d);
        cpu_pulse(1'b1, a, d);
        repeat (3) next_cycle();
    endtask

    function automatic logic [5:0] known6(input logic [4:0] a);
        return (a == 5'h01) ? 6'h2A : 6'h11;
    endfunction

    logic [4:0] addr_at [16];
    int         acks;

    initial begin
        for (int i = 0; i < 32; i++) begin
            ram[i]   = 8'($urandom);
            m_mem[i] = ram[i];
        end
        for (int i = 0; i < NCYC; i++) begin
            s_rv[i] = 0; s_rend[i] = 0; s_color[i] = 0; s_ack[i] = 0; s_rd[i] = 0; s_rdata[i] = 0;
        end
        pal_rdata = 8'h00;
        rst = 1; rend_en = 0; rend_addr = 0; grey = 0;
        cpu_bus.cpu_req = 0; cpu_bus.cpu_wr = 0; cpu_bus.cpu_addr = 0; cpu_bus.cpu_wdata = 0;
        repeat (3) next_cycle();
        check("reset_busy", 32'(cpu_bus.cpu_busy), 32'h0);
        check("reset_valid", 32'(rend_valid), 32'h0);
        rst = 0;
        next_cycle();

        // Write 2A to 01 with the renderer idle
        cpu_bus.cpu_req = 1; cpu_bus.cpu_wr = 1; cpu_bus.cpu_addr = 5'h01; cpu_bus.cpu_wdata = 8'h2A;
        settle();
        check("t1_busy_at_accept", 32'(cpu_bus.cpu_busy), 32'h0);
        next_cycle();
        cpu_bus.cpu_req = 0;
        settle();
        check("t1_pal_wr", 32'(pal_wr), 32'h1);
        check("t1_pal_addr", 32'(pal_addr), 32'h01);
        check("t1_pal_wdata", 32'(pal_wdata), 32'h2A);
        check("t1_busy", 32'(cpu_bus.cpu_busy), 32'h1);
        next_cycle(); settle();
        check("t1_no_early_ack", 32'(cpu_bus.cpu_ack), 32'h0);
        next_cycle(); settle();
        check("t1_ack", 32'(cpu_bus.cpu_ack), 32'h1);
        check("t1_busy_in_ack", 32'(cpu_bus.cpu_busy), 32'h1);
        next_cycle(); settle();
        check("t1_busy_clear", 32'(cpu_bus.cpu_busy), 32'h0);

        cpu_write_idle(5'h00, 8'hC9);
        cpu_write_idle(5'h03, 8'h11);
        cpu_write_idle(5'h05, 8'h15);
        cpu_write_idle(5'h02, 8'h27);

        // Transparent pixel goes to the backdrop entry
        rend_en = 1; rend_addr = 5'h14;
        settle();
        check("t2_remap_addr", 32'(pal_addr), 32'h00);
        next_cycle();
        rend_en = 0;
        next_cycle(); settle();
        check("t2_valid", 32'(rend_valid), 32'h1);
        check("t2_color", 32'(rend_color), 32'h09);

        // Greyscale
        rend_en = 1; rend_addr = 5'h02; grey = 1;
        next_cycle();
        rend_en = 0;
        next_cycle(); settle();
`ifdef PAL_GREY_EN
        check("t6_grey_color", 32'(rend_color), 32'h20);
`else
        check("t6_grey_color", 32'(rend_color), 32'h27);
`endif
        grey = 0;

        // Steal after MAX_WAIT cycles; a second request while busy is dropped
        rend_en = 1; rend_addr = 5'h01; addr_at[0] = 5'h01;
        cpu_bus.cpu_req = 1; cpu_bus.cpu_wr = 0; cpu_bus.cpu_addr = 5'h05;
        acks = 0;
        for (int i = 1; i <= 13; i++) begin
            next_cycle();
            cpu_bus.cpu_req = (i == 3);
            if (i == 3) begin
                cpu_bus.cpu_wr = 1; cpu_bus.cpu_addr = 5'h07; cpu_bus.cpu_wdata = 8'hFF;
            end
            rend_addr  = (i % 2 == 1) ? 5'h01 : 5'h03;
            addr_at[i] = rend_addr;
            settle();
            if (cpu_bus.cpu_ack) acks++;
            if (i == 8) check("t3_rend_before_steal", 32'(pal_addr), 32'(addr_at[8]));
            if (i == 9) begin
                check("t3_steal_addr", 32'(pal_addr), 32'h05);
                check("t3_steal_rd", 32'(pal_wr), 32'h0);
            end
            if (i == 11) begin
                check("t3_ack", 32'(cpu_bus.cpu_ack), 32'h1);
                check("t3_rdata", 32'(cpu_bus.cpu_rdata), 32'h15);
                check("t3_repeat_valid", 32'(rend_valid), 32'h1);
                check("t3_repeat_color", 32'(rend_color), 32'(known6(addr_at[8])));
            end
            if (i == 12) check("t3_busy_clear", 32'(cpu_bus.cpu_busy), 32'h0);
        end
        check("t4_single_ack", 32'(acks), 32'h1);
        rend_en = 0;
        cpu_bus.cpu_wr = 0;
        repeat (3) next_cycle();

        // Reset one cycle after a CPU grant
        cpu_pulse(1'b0, 5'h03, 8'h00);
        settle();
        check("t5_grant_addr", 32'(pal_addr), 32'h03);
        next_cycle();
        rst = 1; rend_en = 1; rend_addr = 5'h07;
        settle();
        check("t5_addr_in_rst", 32'(pal_addr), 32'h00);
        next_cycle();
        rst = 0; rend_en = 0;
        settle();
        check("t5_no_ack", 32'(cpu_bus.cpu_ack), 32'h0);
        check("t5_busy", 32'(cpu_bus.cpu_busy), 32'h0);
        check("t5_valid", 32'(rend_valid), 32'h0);
        check("t5_color", 32'(rend_color), 32'h0);
        check("t5_rdata", 32'(cpu_bus.cpu_rdata), 32'h0);
        next_cycle(); settle();
        check("t5_no_late_ack", 32'(cpu_bus.cpu_ack), 32'h0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            next_cycle();
            rst       = ($urandom_range(0, 199) == 0);
            rend_en   = (n < 1500) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 1) == 1);
            rend_addr = 5'($urandom);
            grey      = 1'($urandom);
            cpu_bus.cpu_req   = ($urandom_range(0, 3) == 0);
            cpu_bus.cpu_wr    = 1'($urandom);
            cpu_bus.cpu_addr  = 5'($urandom);
            cpu_bus.cpu_wdata = 8'($urandom);
        end
        next_cycle();
        rst = 0; rend_en = 0; cpu_bus.cpu_req = 0;
        repeat (12) next_cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
